// File: rtl/audio_seq_synth.sv
// audio_seq_synth
//   Multi-voice step sequencer with a 1-bit sigma-delta mixer. Each voice
//   reads a half-period code from its own row of a writable pattern memory,
//   plays it as a gated square wave, and the voices are summed into a single
//   pulse-density output.
//
//   Optional feature: define AUDSEQ_LOOP_EN to add the loop_end port, which
//   sets an extra wrap point for the step counter.
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-high reset
//   run       1 = play, 0 = hold position and mute
//   wr_en     pattern write strobe (accepted whether or not run is high)
//   wr_ch     channel to write
//   wr_addr   step to write
//   wr_data   half-period code to write (0 = rest)
//   loop_end  last step of the loop (AUDSEQ_LOOP_EN only)
//   audio     sigma-delta mixed output
//   ch_out    per-channel square waves
//   step      current step index
//   beat      one-cycle pulse after each step boundary
module audio_seq_synth #(
  parameter int NUM_CH    = 2,
  parameter int DEPTH     = 128,
  parameter int HP_W      = 7,
  parameter int TICK_DIV  = 1024,
  parameter int SUB_TICKS = 256,
  parameter int SUBSTEPS  = 20,
  parameter int GATE      = 10,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [HP_W-1:0]   wr_data,
`ifdef AUDSEQ_LOOP_EN
  input  logic [ADDR_W-1:0] loop_end,
`endif
  output logic              audio,
  output logic [NUM_CH-1:0] ch_out,
  output logic [ADDR_W-1:0] step,
  output logic              beat
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TC_W  = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
  localparam int SUB_W = (SUBSTEPS > 1) ? $clog2(SUBSTEPS) : 1;
  localparam int ACC_W = $clog2(NUM_CH + 1) + 1;

  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [TC_W-1:0]   TC_MAX   = TC_W'(SUB_TICKS - 1);
  localparam logic [SUB_W-1:0]  SUB_MAX  = SUB_W'(SUBSTEPS - 1);
  localparam logic [ADDR_W-1:0] STEP_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [ACC_W-1:0]  NUM_CH_V = ACC_W'(NUM_CH);

  logic [HP_W-1:0]   mem    [NUM_CH][DEPTH];
  logic [HP_W-1:0]   hp_cur [NUM_CH];
  logic [HP_W-1:0]   hp_ctr [NUM_CH];
  logic [PRE_W-1:0]  presc;
  logic [TC_W-1:0]   tc;
  logic [SUB_W-1:0]  sub;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  ch_sum;
  logic [ACC_W-1:0]  mix_s;
  logic [ADDR_W-1:0] next_step;
  logic              tick;
  logic              boundary;
  logic              gate;
  logic              wrap_pt;

  // Timebase: prescaler -> tick -> tc -> sub -> step boundary.
  assign tick     = run && (presc == PRE_MAX);
  assign boundary = tick && (tc == TC_MAX) && (sub == SUB_MAX);
  assign gate     = run && (32'(sub) < 32'(GATE));

  always_comb begin
    wrap_pt = 1'b0;
`ifdef AUDSEQ_LOOP_EN
    // Lowering loop_end below the current step falls through to DEPTH-1.
    wrap_pt = (step == loop_end) || (step == STEP_MAX);
`else
    wrap_pt = (step == STEP_MAX);
`endif
    next_step = wrap_pt ? '0 : step + 1'b1;
  end

  // Pattern memory. A boundary load in the same cycle as a write to the
  // same address reads the pre-write contents (ordinary flop semantics).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int a = 0; a < DEPTH; a++)
          mem[c][a] <= '0;
    end else if (wr_en && (32'(wr_ch) < 32'(NUM_CH)) && (32'(wr_addr) < 32'(DEPTH))) begin
      mem[wr_ch][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      tc    <= '0;
      sub   <= '0;
      step  <= '0;
      beat  <= 1'b0;
    end else begin
      beat <= boundary;
      if (run) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          tc <= (tc == TC_MAX) ? '0 : tc + 1'b1;
          if (tc == TC_MAX)
            sub <= (sub == SUB_MAX) ? '0 : sub + 1'b1;
        end
        if (boundary)
          step <= next_step;
      end
    end
  end

  // Voices. While stopped, hp_cur tracks memory so resuming plays the
  // current contents of the held step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hp_cur[c] <= '0;
        hp_ctr[c] <= '0;
      end
      ch_out <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!run)
          hp_cur[c] <= mem[c][step];
        else if (boundary)
          hp_cur[c] <= mem[c][next_step];

        if (boundary || !gate || (hp_cur[c] == '0)) begin
          ch_out[c] <= 1'b0;
          hp_ctr[c] <= '0;
        end else if (tick) begin
          if (hp_ctr[c] == hp_cur[c] - 1'b1) begin
            ch_out[c] <= ~ch_out[c];
            hp_ctr[c] <= '0;
          end else begin
            hp_ctr[c] <= hp_ctr[c] + 1'b1;
          end
        end
      end
    end
  end

  // First-order sigma-delta: acc always stays below NUM_CH, so one
  // subtraction is enough and acc+sum never overflows ACC_W.
  always_comb begin
    ch_sum = '0;
    for (int c = 0; c < NUM_CH; c++)
      ch_sum = ch_sum + ACC_W'(ch_out[c]);
    mix_s = acc + ch_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      audio <= 1'b0;
    end else if (!run) begin
      audio <= 1'b0;
    end else if (mix_s >= NUM_CH_V) begin
      audio <= 1'b1;
      acc   <= mix_s - NUM_CH_V;
    end else begin
      audio <= 1'b0;
      acc   <= mix_s;
    end
  end

endmodule

// File: tb/tb_audio_seq_synth.sv
// tb_audio_seq_synth
//   Self-checking bench for audio_seq_synth. The reference model tracks the
//   number of running clock edges and derives tick/step position, gate and
//   square-wave level from that count with plain arithmetic; audio is the
//   carry of the running sum of expected channel levels divided by NUM_CH.
`timescale 1ns/1ps
module tb_audio_seq_synth;
  localparam int NUM_CH     = 2;
  localparam int DEPTH      = 4;
  localparam int HP_W       = 7;
  localparam int TICK_DIV   = 4;
  localparam int SUB_TICKS  = 8;
  localparam int SUBSTEPS   = 4;
  localparam int GATE       = 2;
  localparam int STEP_TICKS = SUB_TICKS * SUBSTEPS;
  localparam int GATE_TICKS = SUB_TICKS * GATE;
  localparam int STEP_CYC   = TICK_DIV * STEP_TICKS;

  // clock / reset / inputs
  logic            clk     = 1'b0;
  logic            rst     = 1'b0;
  logic            run     = 1'b0;
  logic            wr_en   = 1'b0;
  logic [0:0]      wr_ch   = '0;
  logic [1:0]      wr_addr = '0;
  logic [HP_W-1:0] wr_data = '0;
`ifdef AUDSEQ_LOOP_EN
  logic [1:0]      loop_end = 2'd3;
`endif
  logic              audio;
  logic              beat;
  logic [NUM_CH-1:0] ch_out;
  logic [1:0]        step;

  int checks = 0;
  int passes = 0;

  // reference model state
  int                m_n;
  int                m_step;
  int                m_origin;
  int                m_mem [NUM_CH][DEPTH];
  int                m_hp  [NUM_CH];
  longint            m_sum;
  logic [NUM_CH-1:0] exp_ch;
  logic              exp_audio;
  logic              exp_beat;

  audio_seq_synth #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .HP_W(HP_W), .TICK_DIV(TICK_DIV),
    .SUB_TICKS(SUB_TICKS), .SUBSTEPS(SUBSTEPS), .GATE(GATE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
`ifdef AUDSEQ_LOOP_EN
    .loop_end(loop_end),
`endif
    .audio(audio),
    .ch_out(ch_out),
    .step(step),
    .beat(beat)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_n = 0; m_step = 0; m_origin = 0; m_sum = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_hp[c] = 0;
      for (int a = 0; a < DEPTH; a++) m_mem[c][a] = 0;
    end
    exp_ch = '0; exp_audio = 1'b0; exp_beat = 1'b0;
  endfunction

  function automatic int model_next(int s);
`ifdef AUDSEQ_LOOP_EN
    if (s == int'(loop_end) || s == DEPTH - 1) return 0;
`else
    if (s == DEPTH - 1) return 0;
`endif
    return s + 1;
  endfunction

  // Advance the model across one rising edge using the inputs driven now.
  function automatic void model_edge();
    int w_before, w_after, pop;
    bit gate, bnd;
    bnd = 1'b0;
    w_before = (m_n / TICK_DIV) % STEP_TICKS;
    gate = run && (w_before < GATE_TICKS);
    pop = 0;
    for (int c = 0; c < NUM_CH; c++) pop += int'(exp_ch[c]);
    exp_beat = 1'b0;
    if (run) begin
      exp_audio = ((m_sum + pop) / NUM_CH) != (m_sum / NUM_CH);
      m_sum += pop;
      bnd = ((m_n + 1) % STEP_CYC) == 0;
      m_n++;
      if (bnd) begin
        m_step = model_next(m_step);
        exp_beat = 1'b1;
        for (int c = 0; c < NUM_CH; c++) m_hp[c] = m_mem[c][m_step];
        m_origin = 0;
      end
    end else begin
      exp_audio = 1'b0;
      for (int c = 0; c < NUM_CH; c++) m_hp[c] = m_mem[c][m_step];
      m_origin = w_before;  // waveform phase restarts on resume
    end
    w_after = (m_n / TICK_DIV) % STEP_TICKS;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gate && !bnd && m_hp[c] != 0)
        exp_ch[c] = (((w_after - m_origin) / m_hp[c]) % 2) == 1;
      else
        exp_ch[c] = 1'b0;
    end
    if (wr_en) m_mem[wr_ch][wr_addr] = int'(wr_data);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    run = 1'b0; wr_en = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic write_entry(input int ch, input int addr, input int data);
    wr_en = 1'b1; wr_ch = 1'(ch); wr_addr = 2'(addr); wr_data = HP_W'(data);
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic load_random_pattern(input int lo, input int hi);
    for (int a = 0; a < DEPTH; a++)
      for (int c = 0; c < NUM_CH; c++)
        write_entry(c, a, int'($urandom_range(hi, lo)));
    cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int beats;
    beats = 0;
    run = 1'b1;
    #2 rst = 1'b1;
    #10;
    checks++; if (audio !== 1'b0) $display("FAIL reset audio got=%b exp=0", audio); else passes++;
    checks++; if (ch_out !== 2'b00) $display("FAIL reset ch_out got=%b exp=00", ch_out); else passes++;
    checks++; if (step !== 2'd0) $display("FAIL reset step got=%0d exp=0", step); else passes++;
    checks++; if (beat !== 1'b0) $display("FAIL reset beat got=%b exp=0", beat); else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 300; i++) begin
      cycle();
      checks++; if (ch_out !== exp_ch) $display("FAIL empty ch_out n=%0d got=%b exp=%b", m_n, ch_out, exp_ch); else passes++;
      checks++; if (beat !== exp_beat) $display("FAIL empty beat n=%0d got=%b exp=%b", m_n, beat, exp_beat); else passes++;
      checks++; if (step !== 2'(m_step)) $display("FAIL empty step n=%0d got=%0d exp=%0d", m_n, step, m_step); else passes++;
      if (beat === 1'b1) beats++;
    end
    checks++; if (beats != 300 / STEP_CYC) $display("FAIL empty beat_count got=%0d exp=%0d", beats, 300 / STEP_CYC); else passes++;
  endtask

  task automatic test_tone();
    apply_reset();
    write_entry(0, 0, 3);
    cycle();
    run = 1'b1;
    for (int i = 1; i <= DEPTH * STEP_CYC + 8; i++) begin
      cycle();
      checks++; if (ch_out !== exp_ch) $display("FAIL tone ch_out n=%0d got=%b exp=%b", m_n, ch_out, exp_ch); else passes++;
      checks++; if (audio !== exp_audio) $display("FAIL tone audio n=%0d got=%b exp=%b", m_n, audio, exp_audio); else passes++;
      if (i == 12) begin
        checks++; if (ch_out[0] !== 1'b1) $display("FAIL tone first_toggle got=%b exp=1", ch_out[0]); else passes++;
      end
      if (i == 65) begin
        checks++; if (ch_out[0] !== 1'b0) $display("FAIL tone gate_off got=%b exp=0", ch_out[0]); else passes++;
      end
    end
  endtask

  task automatic test_mixer();
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset();
      write_entry(0, 0, 1);
      write_entry(1, 0, (pass == 0) ? 1 : 0);
      cycle();
      run = 1'b1;
      for (int i = 0; i < STEP_CYC; i++) begin
        cycle();
        checks++; if (ch_out !== exp_ch) $display("FAIL mixer%0d ch_out n=%0d got=%b exp=%b", pass, m_n, ch_out, exp_ch); else passes++;
        checks++; if (audio !== exp_audio) $display("FAIL mixer%0d audio n=%0d got=%b exp=%b", pass, m_n, audio, exp_audio); else passes++;
      end
    end
  endtask

  task automatic test_loop();
    logic [1:0] exp_q[$];
    logic [1:0] want;
    apply_reset();
`ifdef AUDSEQ_LOOP_EN
    loop_end = 2'd1;
`endif
    run = 1'b1;
    for (int i = 0; i < 6 * STEP_CYC; i++) begin
`ifdef AUDSEQ_LOOP_EN
      if (i == 3 * STEP_CYC + 10) loop_end = 2'd3;
      if (m_step == 2 && loop_end == 2'd3) loop_end = 2'd1;
`endif
      cycle();
      if (exp_beat) exp_q.push_back(2'(m_step));
      if (beat === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL loop unexpected_beat n=%0d got_step=%0d", m_n, step);
        else begin
          want = exp_q.pop_front();
          if (step !== want) $display("FAIL loop beat_step n=%0d got=%0d exp=%0d", m_n, step, want); else passes++;
        end
      end
      checks++; if (step !== 2'(m_step)) $display("FAIL loop step n=%0d got=%0d exp=%0d", m_n, step, m_step); else passes++;
    end
    checks++; if (exp_q.size() != 0) $display("FAIL loop missing_beats got=%0d exp=0", exp_q.size()); else passes++;
`ifdef AUDSEQ_LOOP_EN
    loop_end = 2'd3;
`endif
  endtask

  task automatic test_hazard();
    apply_reset();
    for (int a = 0; a < DEPTH; a++)
      for (int c = 0; c < NUM_CH; c++)
        write_entry(c, a, int'($urandom_range(6, 1)));
    cycle();
    run = 1'b1;
    for (int i = 1; i <= 2 * DEPTH * STEP_CYC + 8; i++) begin
      wr_en = 1'b0;
      if (i == 30 || i == 30 + 2 * STEP_CYC) begin
        wr_en = 1'b1; wr_ch = 1'b0; wr_addr = 2'(m_step);
        wr_data = HP_W'(m_mem[0][m_step] % 6 + 1);
      end
      if (((m_n + 1) % STEP_CYC) == 0) begin
        wr_en = 1'b1; wr_ch = 1'b1; wr_addr = 2'(model_next(m_step));
        wr_data = HP_W'(m_mem[1][model_next(m_step)] % 6 + 1);
      end
      cycle();
      checks++; if (ch_out !== exp_ch) $display("FAIL hazard ch_out n=%0d got=%b exp=%b", m_n, ch_out, exp_ch); else passes++;
      checks++; if (audio !== exp_audio) $display("FAIL hazard audio n=%0d got=%b exp=%b", m_n, audio, exp_audio); else passes++;
      checks++; if (step !== 2'(m_step)) $display("FAIL hazard step n=%0d got=%0d exp=%0d", m_n, step, m_step); else passes++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_pause();
    int pause_at, held_step;
    apply_reset();
    load_random_pattern(1, 7);
    run = 1'b1;
    pause_at = STEP_CYC + int'($urandom_range(50, 8));
    for (int i = 0; i < pause_at; i++) begin
      cycle();
      checks++; if (ch_out !== exp_ch) $display("FAIL pause_pre ch_out n=%0d got=%b exp=%b", m_n, ch_out, exp_ch); else passes++;
    end
    run = 1'b0;
    held_step = m_step;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks++; if (ch_out !== 2'b00) $display("FAIL pause ch_out got=%b exp=00", ch_out); else passes++;
      checks++; if (audio !== 1'b0) $display("FAIL pause audio got=%b exp=0", audio); else passes++;
      checks++; if (step !== 2'(held_step)) $display("FAIL pause step got=%0d exp=%0d", step, held_step); else passes++;
    end
    run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      checks++; if (ch_out !== exp_ch) $display("FAIL resume ch_out n=%0d got=%b exp=%b", m_n, ch_out, exp_ch); else passes++;
      checks++; if (audio !== exp_audio) $display("FAIL resume audio n=%0d got=%b exp=%b", m_n, audio, exp_audio); else passes++;
      checks++; if (beat !== exp_beat) $display("FAIL resume beat n=%0d got=%b exp=%b", m_n, beat, exp_beat); else passes++;
      checks++; if (step !== 2'(m_step)) $display("FAIL resume step n=%0d got=%0d exp=%0d", m_n, step, m_step); else passes++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    load_random_pattern(0, 7);
    run = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(49, 0) == 0) run = ~run;
      wr_en   = ($urandom_range(19, 0) == 0);
      wr_ch   = 1'($urandom_range(1, 0));
      wr_addr = 2'($urandom_range(3, 0));
      wr_data = HP_W'($urandom_range(7, 0));
      cycle();
      checks++; if (ch_out !== exp_ch) $display("FAIL random ch_out n=%0d got=%b exp=%b", m_n, ch_out, exp_ch); else passes++;
      checks++; if (audio !== exp_audio) $display("FAIL random audio n=%0d got=%b exp=%b", m_n, audio, exp_audio); else passes++;
      checks++; if (beat !== exp_beat) $display("FAIL random beat n=%0d got=%b exp=%b", m_n, beat, exp_beat); else passes++;
      checks++; if (step !== 2'(m_step)) $display("FAIL random step n=%0d got=%0d exp=%0d", m_n, step, m_step); else passes++;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    load_random_pattern(1, 7);
    run = 1'b1;
    for (int i = 0; i < 150; i++) cycle();
    #1 rst = 1'b1;
    #2;
    checks++; if (audio !== 1'b0) $display("FAIL rst_mid audio got=%b exp=0", audio); else passes++;
    checks++; if (ch_out !== 2'b00) $display("FAIL rst_mid ch_out got=%b exp=00", ch_out); else passes++;
    checks++; if (step !== 2'd0) $display("FAIL rst_mid step got=%0d exp=0", step); else passes++;
    checks++; if (beat !== 1'b0) $display("FAIL rst_mid beat got=%b exp=0", beat); else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    run = 1'b1;
    for (int i = 0; i < DEPTH * STEP_CYC + 8; i++) begin
      cycle();
      checks++; if (ch_out !== 2'b00) $display("FAIL rst_mid mem_cleared n=%0d got=%b exp=00", m_n, ch_out); else passes++;
      checks++; if (step !== 2'(m_step)) $display("FAIL rst_mid step_run n=%0d got=%0d exp=%0d", m_n, step, m_step); else passes++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tone();
    test_mixer();
    test_loop();
    test_hazard();
    test_pause();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
